seven_seg_mux_driver: RTL and testbench

SEVEN_SEG_MUX_DRIVER -- requirements
Module: seven_seg_mux_driver

---
 rtl/seven_seg_mux_driver.sv | 202 ++++++++++++++++++++
 tb/tb_seven_seg_mux_driver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_mux_driver.sv
// ============================================================================
// Module : seven_seg_mux_driver
// Brief  : Time-multiplexed hex seven-segment driver with per-digit dead time,
//          tear-free double-buffered updates and optional leading-zero blanking.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seven_seg_mux_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter int LZ_BLANK     = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    load,
  input  logic                    enable,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int c_cnt_w = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int c_idx_w = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(REFRESH_DIV - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(NUM_DIGITS - 1);

  // Scan position
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [c_idx_w-1:0] idx_q, idx_d;

  // Pending (shadow) and display copies of the captured inputs
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [4*NUM_DIGITS-1:0] disp_data_q, disp_data_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0]   disp_blank_q, disp_blank_d;

  // Registered outputs
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;

  logic       w_slot_end;
  logic       w_wrap;
  logic       w_dead;
  logic [3:0] w_sel_nib;
  logic       w_sel_dp;
  logic       w_sel_blank;
  logic       w_sel_lz;
  logic       w_zero_run;

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] pat;
    pat = 8'hFF;
    case (nib)
      4'h0: pat = 8'h03;
      4'h1: pat = 8'h9F;
      4'h2: pat = 8'h25;
      4'h3: pat = 8'h0D;
      4'h4: pat = 8'h99;
      4'h5: pat = 8'h49;
      4'h6: pat = 8'h41;
      4'h7: pat = 8'h1F;
      4'h8: pat = 8'h01;
      4'h9: pat = 8'h19;
      4'hA: pat = 8'h11;
      4'hB: pat = 8'hC1;
      4'hC: pat = 8'h63;
      4'hD: pat = 8'h85;
      4'hE: pat = 8'h61;
      4'hF: pat = 8'h71;
    endcase
    return pat;
  endfunction

  assign w_slot_end = (cnt_q == c_cnt_last);
  assign w_wrap     = enable && w_slot_end && (idx_q == c_idx_last);

  generate
    if (BLANK_CYCLES == 0) begin : g_no_dead
      assign w_dead = 1'b0;
    end else begin : g_dead
      assign w_dead = (cnt_q < c_cnt_w'(BLANK_CYCLES));
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    idx_d = idx_q;
    if (enable) begin
      if (w_slot_end) begin
        cnt_d = '0;
        idx_d = (idx_q == c_idx_last) ? '0 : idx_q + c_idx_w'(1);
      end else begin
        cnt_d = cnt_q + c_cnt_w'(1);
      end
    end
  end

  // A load landing on the wrap bypasses the shadow so it is shown at once.
  always_comb begin
    pend_data_d  = pend_data_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    pend_flag_d  = pend_flag_q;
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    if (w_wrap) begin
      pend_flag_d = 1'b0;
      if (load) begin
        disp_data_d  = data_in;
        disp_dp_d    = dp_in;
        disp_blank_d = blank_in;
      end else if (pend_flag_q) begin
        disp_data_d  = pend_data_q;
        disp_dp_d    = pend_dp_q;
        disp_blank_d = pend_blank_q;
      end
    end else if (load) begin
      pend_data_d  = data_in;
      pend_dp_d    = dp_in;
      pend_blank_d = blank_in;
      pend_flag_d  = 1'b1;
    end
  end

  // Walk from the most significant digit down, tracking the all-zero run.
  always_comb begin
    w_sel_nib   = 4'h0;
    w_sel_dp    = 1'b0;
    w_sel_blank = 1'b0;
    w_sel_lz    = 1'b0;
    w_zero_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run && (disp_data_q[4*k +: 4] == 4'h0);
      if (idx_q == c_idx_w'(k)) begin
        w_sel_nib   = disp_data_q[4*k +: 4];
        w_sel_dp    = disp_dp_q[k];
        w_sel_blank = disp_blank_q[k];
        w_sel_lz    = w_zero_run && (k != 0) && (LZ_BLANK != 0);
      end
    end
  end

  always_comb begin
    an_d         = '1;
    seg_d        = 8'hFF;
    frame_done_d = w_wrap;
    if (enable && !w_dead) begin
      an_d = ~(NUM_DIGITS'(1) << idx_q);
      if (!w_sel_blank && !w_sel_lz) begin
        seg_d    = seg_decode(w_sel_nib);
        seg_d[0] = ~w_sel_dp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      pend_flag_q  <= 1'b0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
      seg_q        <= 8'hFF;
      an_q         <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_flag_q  <= pend_flag_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_mux_driver.sv
// ============================================================================
// Module : tb_seven_seg_mux_driver
// Brief  : Directed and randomized checks of seven_seg_mux_driver against a
//          scan-position reference model; LZ_BLANK=0 and =1 instances side by side.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_mux_driver;

  localparam int N = 4;
  localparam int R = 4;
  localparam int B = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        load;
  logic        enable;
  logic [7:0]  seg0, seg1;
  logic [3:0]  an0, an1;
  logic        fd0, fd1;

  always #5 clk = ~clk;

  seven_seg_mux_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B), .LZ_BLANK(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
    .load(load), .enable(enable), .seg_out(seg0), .an_out(an0), .frame_done(fd0));

  seven_seg_mux_driver #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_CYCLES(B), .LZ_BLANK(1)) u_dut_lz (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
    .load(load), .enable(enable), .seg_out(seg1), .an_out(an1), .frame_done(fd1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one linear position 0..N*R-1 across the frame
  logic [7:0]  seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                8'h01, 8'h19, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};
  int          m_pos;
  logic [15:0] m_data, p_data;
  logic [3:0]  m_dp, m_blank, p_dp, p_blank;
  bit          p_flag;
  logic [3:0]  e_an;
  logic [7:0]  e_seg0, e_seg1;
  logic        e_fd;

  function automatic void m_reset();
    m_pos = 0; m_data = '0; m_dp = '0; m_blank = '0;
    p_data = '0; p_dp = '0; p_blank = '0; p_flag = 1'b0;
  endfunction

  function automatic logic [7:0] m_seg(input int k, input bit lz);
    logic [15:0] upper;
    logic [7:0]  s;
    upper = m_data >> (4 * k);
    if (m_blank[k]) return 8'hFF;
    if (lz && k > 0 && upper == 16'h0) return 8'hFF;
    s = seg_tab[upper[3:0]];
    if (m_dp[k]) s[0] = 1'b0;
    return s;
  endfunction

  task automatic tick();
    int slot, phase;
    @(posedge clk);
    e_an = '1; e_seg0 = 8'hFF; e_seg1 = 8'hFF; e_fd = 1'b0;
    if (!rst_n) begin
      m_reset();
    end else begin
      slot  = m_pos / R;
      phase = m_pos % R;
      if (enable && phase >= B) begin
        e_an   = ~(4'b0001 << slot);
        e_seg0 = m_seg(slot, 1'b0);
        e_seg1 = m_seg(slot, 1'b1);
      end
      e_fd = enable && (m_pos == N * R - 1);
      if (e_fd) begin
        if (load) begin
          m_data = data_in; m_dp = dp_in; m_blank = blank_in;
        end else if (p_flag) begin
          m_data = p_data; m_dp = p_dp; m_blank = p_blank;
        end
        p_flag = 1'b0;
      end else if (load) begin
        p_data = data_in; p_dp = dp_in; p_blank = blank_in; p_flag = 1'b1;
      end
      if (enable) m_pos = (m_pos + 1) % (N * R);
    end
    #1;
    check("an", an0, e_an);
    check("seg", seg0, e_seg0);
    check("frame_done", fd0, e_fd);
    check("an_lz", an1, e_an);
    check("seg_lz", seg1, e_seg1);
    check("frame_done_lz", fd1, e_fd);
  endtask

  task automatic run_until(input int target);
    int guard = 0;
    while (m_pos != target && guard < 200) begin
      tick();
      guard++;
    end
    check("run_until", m_pos, target);
  endtask

  // Leaves the outputs showing digit k lit
  task automatic show(input int k);
    run_until(k * R + B);
    tick();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    data_in = d; dp_in = dp; blank_in = bl; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; load = 1'b0;
    data_in = '0; dp_in = '0; blank_in = '0;
    m_reset();
    repeat (3) tick();
    check("rst_an", an0, 4'hF);
    check("rst_seg", seg0, 8'hFF);
    check("rst_fd", fd0, 1'b0);
    rst_n = 1'b1;

    // Scan order from reset
    tick();
    check("first_dark", an0, 4'hF);
    tick();
    check("first_lit_an", an0, 4'hE);
    check("first_lit_seg", seg0, 8'h03);
    repeat (38) tick();

    // Decode and decimal point
    run_until(3);
    do_load(16'hA5F1, 4'b0100, 4'b0000);
    run_until(0);
    show(0); check("dec_d0", seg0, 8'h9F);
    show(1); check("dec_d1", seg0, 8'h71);
    show(2); check("dec_d2", seg0, 8'h48);
    show(3); check("dec_d3", seg0, 8'h11);

    // Tear-free update mid digit 1
    run_until(1 * R + 2);
    do_load(16'h1234, 4'b0000, 4'b0000);
    show(2); check("old_d2", seg0, 8'h48);
    show(3); check("old_d3", seg0, 8'h11);
    show(0); check("new_d0", seg0, 8'h99);
    show(1); check("new_d1", seg0, 8'h0D);
    show(2); check("new_d2", seg0, 8'h25);
    show(3); check("new_d3", seg0, 8'h9F);

    // Load exactly in the wrap cycle, with a stale pending load beforehand
    run_until(5);
    do_load(16'hBEEF, 4'b0000, 4'b0000);
    run_until(N * R - 1);
    do_load(16'hC0DE, 4'b0000, 4'b0000);
    show(0); check("wrap_d0", seg0, 8'h61);
    show(3); check("wrap_d3", seg0, 8'h63);
    run_until(0);
    show(1); check("wrap_next_d1", seg0, 8'h85);

    // Leading-zero blanking
    run_until(3);
    do_load(16'h0070, 4'b0000, 4'b0000);
    run_until(0);
    show(0); check("lz_d0", seg1, 8'h03);
    show(1); check("lz_d1", seg1, 8'h1F);
    show(2); check("lz_d2", seg1, 8'hFF);
    show(3); check("lz_d3", seg1, 8'hFF); check("nolz_d3", seg0, 8'h03);
    run_until(3);
    do_load(16'h0000, 4'b0000, 4'b0000);
    run_until(0);
    show(0); check("lz0_d0", seg1, 8'h03);
    show(1); check("lz0_d1", seg1, 8'hFF);
    show(3); check("lz0_d3", seg1, 8'hFF);

    // Enable dropped mid digit 2
    run_until(2 * R + 2);
    enable = 1'b0;
    repeat (5) tick();
    check("dis_an", an0, 4'hF);
    check("dis_seg", seg0, 8'hFF);
    enable = 1'b1;
    tick();
    check("resume_an", an0, 4'b1011);
    repeat (20) tick();

    // Asynchronous reset between edges discards a pending load
    run_until(3);
    do_load(16'h9999, 4'b1111, 4'b0000);
    run_until(6);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_an", an0, 4'hF);
    check("arst_seg", seg0, 8'hFF);
    check("arst_fd", fd0, 1'b0);
    check("arst_an_lz", an1, 4'hF);
    check("arst_seg_lz", seg1, 8'hFF);
    repeat (2) tick();
    rst_n = 1'b1;
    show(0); check("post_rst_d0", seg0, 8'h03);
    run_until(0);
    show(1); check("post_rst_d1", seg0, 8'h03);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      enable   = ($urandom_range(0, 9) != 0);
      load     = ($urandom_range(0, 5) == 0);
      data_in  = 16'($urandom) >> (4 * $urandom_range(0, 4));
      dp_in    = 4'($urandom);
      blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      tick();
    end
    load = 1'b0;
    enable = 1'b1;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
